// File: rtl/hebb_trainer_if.sv
// Write port from the Hebbian trainer into the link memory.
// The master drives the weight write; the slave (memory) returns ready.
interface hebb_trainer_if #(
   parameter int unsigned AW = 10,
   parameter int unsigned WW = 5
);
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic signed [WW-1:0] wr_data;
   logic                 wr_ready;

   modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/hebb_trainer.sv
// Hebbian weight trainer: accumulates +/-1 agreement over NPAT stored patterns
// per link (i,j) and streams all N*N saturated weights row-major to link memory.
module hebb_trainer #(
   parameter int unsigned N    = 25,
   parameter int unsigned NPAT = 4,
   parameter int unsigned WW   = 5,
   parameter int unsigned AW   = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [NPAT*N-1:0] pats,
   hebb_trainer_if.master    wr,
   output logic              busy,
   output logic              done
);
   localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned KW   = (NPAT > 1) ? $clog2(NPAT) : 1;
   localparam int unsigned PW   = (NPAT * N > 1) ? $clog2(NPAT * N) : 1;
   localparam int unsigned ACCW = $clog2(NPAT + 1) + 1;
   localparam int          SAT_MAX = (2 ** (WW - 1)) - 1;
   localparam int          SAT_MIN = -(2 ** (WW - 1));

   typedef enum logic [1:0] {IDLE, ACC, WRITE, DONE} state_t;

   state_t                 state;
   logic [NPAT*N-1:0]      pat_q;
   logic [IW-1:0]          i;
   logic [IW-1:0]          j;
   logic [KW-1:0]          k;
   logic signed [ACCW-1:0] acc;

   logic [PW-1:0]          idx_i;
   logic [PW-1:0]          idx_j;
   logic signed [ACCW-1:0] acc_next;
   int                     acc_int;
   int                     sat_val;
   logic                   last_i;
   logic                   last_j;

   always_comb begin
      idx_i    = PW'(k * N + i);
      idx_j    = PW'(k * N + j);
      acc_next = (pat_q[idx_i] == pat_q[idx_j]) ? acc + ACCW'(1) : acc - ACCW'(1);
      acc_int  = int'(acc_next);
      sat_val  = acc_int;
      if (acc_int > SAT_MAX) begin
         sat_val = SAT_MAX;
      end else if (acc_int < SAT_MIN) begin
         sat_val = SAT_MIN;
      end
      last_i = (i == IW'(N - 1));
      last_j = (j == IW'(N - 1));
   end

   // The final ACC cycle loads the write registers directly so wr_en rises
   // exactly NPAT cycles after start and each link costs NPAT+1 cycles.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         pat_q      <= '0;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         acc        <= '0;
         wr.wr_en   <= 1'b0;
         wr.wr_addr <= '0;
         wr.wr_data <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pat_q <= pats;
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= ACC;
               end
            end
            ACC: begin
               acc <= acc_next;
               if (k == KW'(NPAT - 1)) begin
                  k          <= '0;
                  wr.wr_en   <= 1'b1;
                  wr.wr_addr <= AW'(i * N + j);
                  wr.wr_data <= (i == j) ? '0 : WW'(sat_val);
                  state      <= WRITE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            WRITE: begin
               if (wr.wr_ready) begin
                  wr.wr_en <= 1'b0;
                  if (last_i && last_j) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     if (last_j) begin
                        j <= '0;
                        i <= i + IW'(1);
                     end else begin
                        j <= j + IW'(1);
                     end
                     k     <= '0;
                     acc   <= '0;
                     state <= ACC;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hebb_trainer.sv
// Scoreboard bench for hebb_trainer: expected writes are queued by the stimulus
// and popped by per-DUT monitors on each accepted write.
module tb_hebb_trainer;
   localparam int unsigned N    = 25;
   localparam int unsigned NPAT = 4;
   localparam int unsigned WW   = 5;
   localparam int unsigned WWB  = 3;
   localparam int unsigned AW   = 10;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              start_a = 1'b0;
   logic              start_b = 1'b0;
   logic [NPAT*N-1:0] pats_a = '0;
   logic [NPAT*N-1:0] pats_b = '0;
   logic              busy_a, done_a, busy_b, done_b;

   hebb_trainer_if #(.AW(AW), .WW(WW))  wa ();
   hebb_trainer_if #(.AW(AW), .WW(WWB)) wb ();

   hebb_trainer #(.N(N), .NPAT(NPAT), .WW(WW), .AW(AW)) dut_a (
      .CLK(CLK), .RST(RST), .start(start_a), .pats(pats_a),
      .wr(wa), .busy(busy_a), .done(done_a)
   );

   hebb_trainer #(.N(N), .NPAT(NPAT), .WW(WWB), .AW(AW)) dut_b (
      .CLK(CLK), .RST(RST), .start(start_b), .pats(pats_b),
      .wr(wb), .busy(busy_b), .done(done_b)
   );

   always #5 CLK = ~CLK;

   wr_t q_a[$];
   wr_t q_b[$];
   wr_t ea, eb;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   int  acc_a = 0;
   int  stall_a = 0;
   int  start_cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   always @(negedge CLK) begin
      if (RST && wa.wr_en) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_write", 1, 0);
         end else if (wa.wr_ready) begin
            ea = q_a.pop_front();
            check("a_addr", int'(wa.wr_addr), ea.addr);
            check("a_data", int'(wa.wr_data), ea.data);
            acc_a++;
         end else begin
            check("a_hold_addr", int'(wa.wr_addr), q_a[0].addr);
            check("a_hold_data", int'(wa.wr_data), q_a[0].data);
            stall_a++;
         end
      end
   end

   always @(negedge CLK) begin
      if (RST && wb.wr_en) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_write", 1, 0);
         end else begin
            eb = q_b.pop_front();
            check("b_addr", int'(wb.wr_addr), eb.addr);
            check("b_data", int'(wb.wr_data), eb.data);
         end
      end
   end

   function automatic int ref_w(input logic [NPAT*N-1:0] pv, input int i, input int j, input int ww);
      int s, hi, lo;
      s  = 0;
      hi = (1 << (ww - 1)) - 1;
      lo = -(1 << (ww - 1));
      if (i == j) return 0;
      for (int p = 0; p < NPAT; p++) s += (pv[p*N+i] == pv[p*N+j]) ? 1 : -1;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      return s;
   endfunction

   // kind 0: all-ones (+4 off-diagonal); kind 1: pattern0=1 only; kind 2: model
   task automatic push_a(input int kind, input logic [NPAT*N-1:0] pv);
      int d;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (kind == 0)      d = (i == j) ? 0 : 4;
            else if (kind == 1) d = (i == j) ? 0 : ((i == 0 || j == 0) ? 2 : 4);
            else                d = ref_w(pv, i, j, WW);
            q_a.push_back('{addr: i * N + j, data: d});
         end
      end
   endtask

   task automatic run_a(input logic [NPAT*N-1:0] pv, input int want_cycles, input string tag);
      bit seen;
      seen = 1'b0;
      @(posedge CLK); #1;
      pats_a  = pv;
      start_a = 1'b1;
      @(posedge CLK); #1;
      start_a   = 1'b0;
      start_cyc = cyc;
      check({tag, "_busy_run"}, int'(busy_a), 1);
      for (int c = 0; c < 6000 && !seen; c++) begin
         @(posedge CLK); #1;
         if (done_a) seen = 1'b1;
      end
      check({tag, "_done_seen"}, int'(seen), 1);
      check({tag, "_cycles"}, cyc - start_cyc, want_cycles);
      check({tag, "_busy_at_done"}, int'(busy_a), 0);
      check({tag, "_queue_left"}, q_a.size(), 0);
      @(posedge CLK); #1;
      check({tag, "_done_pulse"}, int'(done_a), 0);
   endtask

   logic [NPAT*N-1:0] p_ones;
   logic [NPAT*N-1:0] p_one;
   logic [NPAT*N-1:0] p_mix;

   initial begin
      bit seen;
      wa.wr_ready = 1'b1;
      wb.wr_ready = 1'b1;
      p_ones = '1;
      p_one  = '0;
      p_one[0] = 1'b1;
      p_mix  = {25'h0000ABC, 25'h1FFF000, 25'h0F0F0F0, 25'h1555555};

      repeat (3) @(posedge CLK);
      #1;
      check("rst_wr_en", int'(wa.wr_en), 0);
      check("rst_wr_addr", int'(wa.wr_addr), 0);
      check("rst_wr_data", int'(wa.wr_data), 0);
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      RST = 1'b1;

      // all ones, ready high
      push_a(0, p_ones);
      run_a(p_ones, N * N * (NPAT + 1), "t1");

      // single pixel set in pattern 0
      push_a(1, p_one);
      run_a(p_one, N * N * (NPAT + 1), "t2");

      // saturating 3-bit weights on second instance
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            q_b.push_back('{addr: i * N + j, data: (i == j) ? 0 : 3});
      @(posedge CLK); #1;
      pats_b  = p_ones;
      start_b = 1'b1;
      @(posedge CLK); #1;
      start_b = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6000 && !seen; c++) begin
         @(posedge CLK); #1;
         if (done_b) seen = 1'b1;
      end
      check("t3_done_seen", int'(seen), 1);
      check("t3_queue_left", q_b.size(), 0);

      // first write stalled for 10 cycles
      push_a(0, p_ones);
      stall_a = 0;
      wa.wr_ready = 1'b0;
      fork
         run_a(p_ones, N * N * (NPAT + 1) + 10, "t4");
         begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
               @(posedge CLK); #1;
               if (wa.wr_en) seen = 1'b1;
            end
            check("t4_wr_en_seen", int'(seen), 1);
            check("t4_first_latency", cyc - start_cyc, NPAT);
            repeat (10) @(posedge CLK);
            #1 wa.wr_ready = 1'b1;
         end
      join
      check("t4_stall_cycles", stall_a, 10);

      // reset after 100 accepted writes
      push_a(1, p_one);
      acc_a = 0;
      fork
         begin
            @(posedge CLK); #1;
            pats_a  = p_one;
            start_a = 1'b1;
            @(posedge CLK); #1;
            start_a = 1'b0;
         end
      join
      seen = 1'b0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(posedge CLK); #1;
         if (acc_a >= 100 && wa.wr_en) seen = 1'b1;
      end
      check("t5_reached_100", int'(seen), 1);
      RST = 1'b0;
      #1;
      check("t5_wr_en_abort", int'(wa.wr_en), 0);
      check("t5_busy_abort", int'(busy_a), 0);
      check("t5_accepted", acc_a, 100);
      q_a.delete();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check("t5_idle_after_rst", int'(wa.wr_en), 0);
      push_a(1, p_one);
      run_a(p_one, N * N * (NPAT + 1), "t5");

      // start re-pulsed and pats changed mid-run
      push_a(2, p_mix);
      fork
         run_a(p_mix, N * N * (NPAT + 1), "t6");
         begin
            repeat (50) @(posedge CLK);
            #1;
            pats_a  = ~p_mix;
            start_a = 1'b1;
            @(posedge CLK); #1;
            start_a = 1'b0;
            repeat (700) @(posedge CLK);
            #1 start_a = 1'b1;
            @(posedge CLK); #1;
            start_a = 1'b0;
         end
      join
      repeat (5) @(posedge CLK);
      #1;
      check("t6_no_restart", int'(busy_a), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
